coletor_digitos: RTL and testbench

Keypad digit collector for the electronic lock, directly upstream of `setup` and the operational comparator. Takes single-cycle decoded key strobes and accumulates decimal digits into a right-aligned `senhaPac_t` buffer, with unused positions holding 4'hF. On the enter key it presents the packet with a one-cycle `digitos_valid` strobe. Clear key, inactivity timeout and `enable` deassertion discard the partial entry.

---
 rtl/coletor_digitos_pkg.sv | 26 ++
 rtl/coletor_digitos_timeout.sv | 45 ++++
 rtl/coletor_digitos.sv | 142 ++++++++++++++
 tb/tb_coletor_digitos.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/coletor_digitos_pkg.sv
// Shared types and constants for the lock keypad path: packed password
// buffer, special key codes and the "empty" filler values.
package coletor_digitos_pkg;

    localparam int N_DIGITOS = 20;

    typedef logic [N_DIGITOS*4-1:0] senhaPac_t;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_ENT   = 4'hB;
    localparam logic [3:0] DIG_VAZIO = 4'hF;

    localparam senhaPac_t  PAC_VAZIO = {N_DIGITOS{DIG_VAZIO}};
    localparam logic [4:0] MAX_DIG   = 5'd20;

    // True for decimal digit codes 0..9.
    function automatic logic is_digito(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    // Newest digit enters nibble 0; the oldest nibble falls off the top.
    function automatic senhaPac_t shift_in(input senhaPac_t v, input logic [3:0] d);
        return {v[N_DIGITOS*4-5:0], d};
    endfunction

endpackage

// File: rtl/coletor_digitos_timeout.sv
// Idle-cycle counter shared by the digit collector and the auto-lock timer.
// reload forces the count back to zero; while run is high the count advances
// and expired is raised on the cycle the count sits at TIMEOUT_CYCLES-1.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int             CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload wins, then advance while running, parking at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = ZERO;
        end else if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/coletor_digitos.sv
// Keypad digit collector: accumulates decimal key strobes into a
// right-aligned packet (newest digit in nibble 0, unused nibbles 4'hF) and
// presents it with a one-cycle digitos_valid strobe on the enter key.
// Clear, inactivity timeout and enable low discard the partial entry.
module coletor_digitos
    import coletor_digitos_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic [4:0] digit_count,
    output logic       entrada_ativa
);

    typedef enum logic [1:0] {
        VAZIO  = 2'd0,
        COLETA = 2'd1,
        ENVIA  = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    senhaPac_t  valor_q,  valor_d;
    logic [4:0] cont_q,   cont_d;
    logic       valid_q,  valid_d;
    logic       ativa_q,  ativa_d;

    logic       reload_s;
    logic       run_s;
    logic       expired_s;
    logic       tecla_dig_s;
    logic       tecla_clr_s;
    logic       tecla_ent_s;

    assign tecla_dig_s = key_valid && is_digito(key_code);
    assign tecla_clr_s = key_valid && (key_code == KEY_CLR);
    assign tecla_ent_s = key_valid && (key_code == KEY_ENT);
    assign run_s       = (estado_q == COLETA);

    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .reload  (reload_s),
        .run     (run_s),
        .expired (expired_s)
    );

    // Next-state, buffer and count logic; the timer is held at zero outside COLETA.
    always_comb begin
        estado_d = estado_q;
        valor_d  = valor_q;
        cont_d   = cont_q;
        reload_s = (estado_q != COLETA);

        if (!enable) begin
            estado_d = VAZIO;
            valor_d  = PAC_VAZIO;
            cont_d   = 5'd0;
            reload_s = 1'b1;
        end else begin
            case (estado_q)
                VAZIO: begin
                    if (tecla_dig_s) begin
                        estado_d = COLETA;
                        valor_d  = shift_in(valor_q, key_code);
                        cont_d   = 5'd1;
                        reload_s = 1'b1;
                    end else begin
                        estado_d = VAZIO;
                    end
                end
                COLETA: begin
                    if (tecla_dig_s) begin
                        valor_d  = shift_in(valor_q, key_code);
                        cont_d   = (cont_q == MAX_DIG) ? MAX_DIG : (cont_q + 5'd1);
                        reload_s = 1'b1;
                    end else if (tecla_clr_s) begin
                        estado_d = VAZIO;
                        valor_d  = PAC_VAZIO;
                        cont_d   = 5'd0;
                    end else if (tecla_ent_s) begin
                        estado_d = ENVIA;
                    end else if (expired_s) begin
                        estado_d = VAZIO;
                        valor_d  = PAC_VAZIO;
                        cont_d   = 5'd0;
                    end else begin
                        estado_d = COLETA;
                    end
                end
                ENVIA: begin
                    // Packet has been presented for one cycle; any key now is dropped.
                    estado_d = VAZIO;
                    valor_d  = PAC_VAZIO;
                    cont_d   = 5'd0;
                end
                default: begin
                    estado_d = VAZIO;
                    valor_d  = PAC_VAZIO;
                    cont_d   = 5'd0;
                end
            endcase
        end
    end

    // Registered flags derived from the next state so outputs come straight from flops.
    always_comb begin
        valid_d = (estado_d == ENVIA);
        ativa_d = (cont_d != 5'd0) || (estado_d == ENVIA);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= VAZIO;
            valor_q  <= PAC_VAZIO;
            cont_q   <= 5'd0;
            valid_q  <= 1'b0;
            ativa_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            valor_q  <= valor_d;
            cont_q   <= cont_d;
            valid_q  <= valid_d;
            ativa_q  <= ativa_d;
        end
    end

    assign digitos_value = valor_q;
    assign digit_count   = cont_q;
    assign entrada_ativa = ativa_q;
    // Dropping enable on the ENVIA cycle must suppress the strobe immediately.
    assign digitos_valid = valid_q & enable;

endmodule

// File: tb/tb_coletor_digitos.sv
// Bench for coletor_digitos: a queue-based model of the entry tracks the
// expected outputs and is compared with the DUT every cycle; directed
// scenarios pin the model to hand-computed packets, then random keys follow.
module tb_coletor_digitos;
    import coletor_digitos_pkg::*;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    logic [4:0] digit_count;
    logic       entrada_ativa;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: digits held (oldest first), send pending, idle cycles.
    logic [3:0] mq[$];
    bit         m_send = 1'b0;
    int         m_idle = 0;

    coletor_digitos #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .digit_count   (digit_count),
        .entrada_ativa (entrada_ativa)
    );

    always #5 clk = ~clk;

    function automatic senhaPac_t pack_model();
        senhaPac_t v = PAC_VAZIO;
        int n = mq.size();
        for (int i = 0; i < n; i++) v[4*i +: 4] = mq[n-1-i];
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_send = 1'b0;
        m_idle = 0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_step();
        if (rst || !enable || m_send) begin
            model_clear();
        end else if (key_valid && key_code <= 4'd9) begin
            mq.push_back(key_code);
            if (mq.size() > 20) void'(mq.pop_front());
            m_idle = 0;
        end else if (key_valid && key_code == KEY_CLR) begin
            model_clear();
        end else if (key_valid && key_code == KEY_ENT && mq.size() > 0) begin
            m_send = 1'b1;
        end else if (mq.size() > 0) begin
            if (m_idle == T - 1) model_clear();
            else m_idle++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            senhaPac_t  ev;
            logic [4:0] ec;
            logic       evld;
            logic       eat;
            ev   = pack_model();
            ec   = 5'(mq.size());
            evld = m_send && enable;
            eat  = (mq.size() != 0) || m_send;
            checks += 4;
            if (digitos_value !== ev) begin
                errors++;
                $display("FAIL value t=%0t got %h want %h", $time, digitos_value, ev);
            end
            if (digit_count !== ec) begin
                errors++;
                $display("FAIL count t=%0t got %0d want %0d", $time, digit_count, ec);
            end
            if (digitos_valid !== evld) begin
                errors++;
                $display("FAIL valid t=%0t got %b want %b", $time, digitos_valid, evld);
            end
            if (entrada_ativa !== eat) begin
                errors++;
                $display("FAIL ativa t=%0t got %b want %b", $time, entrada_ativa, eat);
            end
        end
    end

    task automatic tick(input bit r, input bit en, input bit kv, input logic [3:0] kc);
        rst = r; enable = en; key_valid = kv; key_code = kc;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] kc);
        tick(1'b0, 1'b1, 1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic pin(input string name, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [79:0] lit;
        tick(1'b1, 1'b1, 1'b0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 4'h0);
        chk_en = 1'b1;
        pin("reset_value", digitos_value, PAC_VAZIO);
        pin("reset_count", 80'(digit_count), 80'd0);

        // 1,2,3,4,# -> one pulse with {16xF,1,2,3,4}
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENT);
        lit = 80'hFFFFFFFFFFFFFFFF1234;
        pin("t1_model", pack_model(), lit);
        pin("t1_value", digitos_value, lit);
        pin("t1_valid", 80'(digitos_valid), 80'd1);
        idle(1);
        pin("t1_after", digitos_value, PAC_VAZIO);
        pin("t1_count0", 80'(digit_count), 80'd0);

        // 9,8,*,5,# -> {19xF,5}, counts 1,2,0,1
        key(4'h9); pin("t2_c1", 80'(digit_count), 80'd1);
        key(4'h8); pin("t2_c2", 80'(digit_count), 80'd2);
        key(KEY_CLR); pin("t2_c0", 80'(digit_count), 80'd0);
        key(4'h5); pin("t2_c1b", 80'(digit_count), 80'd1);
        key(KEY_ENT);
        lit = 80'hFFFFFFFFFFFFFFFFFFF5;
        pin("t2_model", pack_model(), lit);
        pin("t2_value", digitos_value, lit);
        idle(1);

        // 22 digits keep only the last 20
        for (int i = 0; i < 22; i++)
            key(i < 20 ? 4'(i % 10) : (i == 20 ? 4'h7 : 4'h3));
        pin("t3_count", 80'(digit_count), 80'd20);
        key(KEY_ENT);
        lit = 80'h23456789012345678973;
        pin("t3_model", pack_model(), lit);
        pin("t3_value", digitos_value, lit);
        idle(1);

        // Timeout expiry and a key arriving on the expiry cycle
        key(4'h4); key(4'h5); idle(T - 1);
        pin("t4_before", 80'(digit_count), 80'd2);
        idle(1);
        pin("t4_expired", digitos_value, PAC_VAZIO);
        key(4'h4); key(4'h5); idle(T - 1); key(4'h6);
        pin("t4_keywins", 80'(digit_count), 80'd3);
        lit = 80'hFFFFFFFFFFFFFFFFF456;
        pin("t4_value", digitos_value, lit);
        key(KEY_CLR);

        // Enter and ignored codes in VAZIO; digit during ENVIA dropped
        key(KEY_ENT); key(4'hC);
        pin("t5_idle_ativa", 80'(entrada_ativa), 80'd0);
        key(4'h1); key(KEY_ENT); key(4'h7);
        pin("t5_env_drop", digitos_value, PAC_VAZIO);
        pin("t5_env_cnt", 80'(digit_count), 80'd0);

        // enable low mid-entry and on the ENVIA cycle
        key(4'h1); key(4'h2); key(4'h3);
        tick(1'b0, 1'b0, 1'b0, 4'h0);
        pin("t6_en_clear", digitos_value, PAC_VAZIO);
        idle(1);
        key(4'h1); key(KEY_ENT);
        enable = 1'b0; key_valid = 1'b0;
        #1;
        pin("t6_gated", 80'(digitos_valid), 80'd0);
        @(posedge clk); #1;
        pin("t6_after", 80'(digit_count), 80'd0);
        idle(1);

        // Synchronous reset mid-entry
        key(4'h1); key(4'h2);
        tick(1'b1, 1'b1, 1'b1, 4'h3);
        pin("t7_rst_value", digitos_value, PAC_VAZIO);
        pin("t7_rst_ativa", 80'(entrada_ativa), 80'd0);

        // Randomized traffic: busy phase then sparse phase to reach timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                int  sel;
                bit  kv;
                logic [3:0] kc;
                kv  = ($urandom_range(0, 99) < (ph == 0 ? 60 : 6));
                sel = $urandom_range(0, 99);
                if (sel < 80)      kc = 4'($urandom_range(0, 9));
                else if (sel < 85) kc = KEY_CLR;
                else if (sel < 93) kc = KEY_ENT;
                else               kc = 4'($urandom_range(12, 15));
                tick($urandom_range(0, 199) == 0, $urandom_range(0, 99) > 1, kv, kc);
            end
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
